// File: rtl/except_redirect_if.sv
// except_redirect_if
//   Bundles the signals between the exception decoder, CP0, fetch and hazard
//   logic and except_redirect_ctrl.
//   slave  : controller side (decoder/pipeline status in, CP0/fetch controls out)
//   master : environment side (drives status, observes controls)
//   Inputs to the controller : is_except, except_type, except_pc, pc_m,
//                              in_delayslot_m, stall_m, inst_pending, redirect_ready
//   Outputs of the controller: flush_all, flush_f, cp0_except_we, cp0_eret,
//                              cp0_exccode, cp0_bd, cp0_epc_wdata,
//                              redirect_valid, redirect_pc, busy
interface except_redirect_if;
  logic        is_except;
  logic [31:0] except_type;
  logic [31:0] except_pc;
  logic [31:0] pc_m;
  logic        in_delayslot_m;
  logic        stall_m;
  logic        inst_pending;
  logic        redirect_ready;

  logic        flush_all;
  logic        flush_f;
  logic        cp0_except_we;
  logic        cp0_eret;
  logic [4:0]  cp0_exccode;
  logic        cp0_bd;
  logic [31:0] cp0_epc_wdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  modport slave (
    input  is_except, except_type, except_pc, pc_m, in_delayslot_m,
           stall_m, inst_pending, redirect_ready,
    output flush_all, flush_f, cp0_except_we, cp0_eret, cp0_exccode,
           cp0_bd, cp0_epc_wdata, redirect_valid, redirect_pc, busy
  );

  modport master (
    output is_except, except_type, except_pc, pc_m, in_delayslot_m,
           stall_m, inst_pending, redirect_ready,
    input  flush_all, flush_f, cp0_except_we, cp0_eret, cp0_exccode,
           cp0_bd, cp0_epc_wdata, redirect_valid, redirect_pc, busy
  );
endinterface

// File: rtl/except_redirect_ctrl.sv
// except_redirect_ctrl
//   Sequences the pipeline response to an exception/ERET decoded at M:
//   commits it to CP0 once, flushes F..M, holds a PC redirect until fetch
//   takes it, then drains in-flight instruction fetches before releasing.
//   Ports:
//     clk    - rising-edge clock
//     resetn - asynchronous active-low reset
//     bus    - except_redirect_if.slave (see interface header for signals)
//   Parameters:
//     MIN_DRAIN - minimum cycles spent in DRAIN (1..15)
//     ERET_CODE - except_type[4:0] value meaning ERET
module except_redirect_ctrl #(
  parameter int         MIN_DRAIN = 2,
  parameter logic [4:0] ERET_CODE = 5'h0e
) (
  input  logic              clk,
  input  logic              resetn,
  except_redirect_if.slave  bus
);

  if (MIN_DRAIN < 1 || MIN_DRAIN > 15) begin : g_bad_param
    $error("MIN_DRAIN must be in 1..15");
  end

  localparam logic [3:0] DRAIN_INIT = 4'(MIN_DRAIN - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REDIRECT = 2'd1,
    S_DRAIN    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  drain_q, drain_d;
  logic [31:0] tgt_q;

  logic accept;
  logic is_eret;
  logic handshake;
  logic unused_type_hi;

  assign unused_type_hi = ^bus.except_type[31:5];

  assign is_eret   = (bus.except_type[4:0] == ERET_CODE);
  // resetn gates accept so no pulse can escape while reset is held.
  assign accept    = resetn & (state_q == S_IDLE) & bus.is_except & ~bus.stall_m;
  assign handshake = (state_q == S_REDIRECT) & bus.redirect_ready;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      drain_q <= 4'd0;
      tgt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      // Target is captured only on accept, so it stays frozen while
      // redirect_valid is up and later is_except pulses cannot disturb it.
      if (accept) tgt_q <= bus.except_pc;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (handshake) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_INIT;
        end
      end
      S_DRAIN: begin
        // Counter saturates at 0; inst_pending can hold us here indefinitely.
        if (drain_q != 4'd0) drain_d = drain_q - 4'd1;
        if (drain_q == 4'd0 && !bus.inst_pending) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        drain_d = 4'd0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    bus.flush_all      = accept;
    bus.flush_f        = accept | (state_q != S_IDLE);
    bus.cp0_except_we  = accept & ~is_eret;
    bus.cp0_eret       = accept & is_eret;
    bus.cp0_exccode    = 5'd0;
    bus.cp0_bd         = 1'b0;
    bus.cp0_epc_wdata  = 32'd0;
    bus.redirect_valid = (state_q == S_REDIRECT);
    bus.redirect_pc    = tgt_q;
    bus.busy           = (state_q != S_IDLE);
    if (accept && !is_eret) begin
      bus.cp0_exccode   = bus.except_type[4:0];
      bus.cp0_bd        = bus.in_delayslot_m;
      // Delay-slot faults restart at the branch, one word back (wraps mod 2^32).
      bus.cp0_epc_wdata = bus.in_delayslot_m ? (bus.pc_m - 32'd4) : bus.pc_m;
    end
  end

endmodule

// File: tb/tb_except_redirect_ctrl.sv
module tb_except_redirect_ctrl;
  localparam int MIN_DRAIN = 2;

  logic clk;
  logic resetn;
  except_redirect_if bus ();

  except_redirect_ctrl #(.MIN_DRAIN(MIN_DRAIN), .ERET_CODE(5'h0e)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Transaction-level reference: an outstanding redirect (with its target)
  // and, once fetch takes it, the number of cycles already spent draining.
  bit          m_redir;
  logic [31:0] m_tgt;
  int          m_age;   // -1: not draining

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit m_idle();
    return !m_redir && m_age < 0;
  endfunction

  function automatic bit m_accept();
    return resetn && m_idle() && bus.is_except && !bus.stall_m;
  endfunction

  task automatic model_reset();
    m_redir = 0;
    m_tgt   = 32'd0;
    m_age   = -1;
  endtask

  task automatic check_model();
    bit acc, eret;
    acc  = m_accept();
    eret = (bus.except_type[4:0] == 5'h0e);
    chk("flush_all", 32'(bus.flush_all), 32'(acc));
    chk("flush_f",   32'(bus.flush_f),   32'(acc || !m_idle()));
    chk("except_we", 32'(bus.cp0_except_we), 32'(acc && !eret));
    chk("eret",      32'(bus.cp0_eret),  32'(acc && eret));
    chk("rvalid",    32'(bus.redirect_valid), 32'(m_redir));
    chk("busy",      32'(bus.busy),      32'(!m_idle()));
    if (!(acc && eret)) begin
      if (acc) begin
        chk("exccode", 32'(bus.cp0_exccode), 32'(bus.except_type[4:0]));
        chk("bd",      32'(bus.cp0_bd),      32'(bus.in_delayslot_m));
        chk("epc",     bus.cp0_epc_wdata,
            bus.in_delayslot_m ? bus.pc_m - 32'd4 : bus.pc_m);
      end else begin
        chk("exccode0", 32'(bus.cp0_exccode), 32'd0);
        chk("bd0",      32'(bus.cp0_bd),      32'd0);
        chk("epc0",     bus.cp0_epc_wdata,    32'd0);
      end
    end
    if (m_redir)  chk("rpc", bus.redirect_pc, m_tgt);
    if (!resetn)  chk("rpc_rst", bus.redirect_pc, 32'd0);
  endtask

  task automatic drive(input logic rst, input logic exc, input logic [31:0] typ,
                       input logic [31:0] tgt, input logic [31:0] pc, input logic bd,
                       input logic stl, input logic pend, input logic rdy);
    @(negedge clk);
    resetn             = rst;
    bus.is_except      = exc;
    bus.except_type    = typ;
    bus.except_pc      = tgt;
    bus.pc_m           = pc;
    bus.in_delayslot_m = bd;
    bus.stall_m        = stl;
    bus.inst_pending   = pend;
    bus.redirect_ready = rdy;
    #1;
    if (!rst) model_reset();
    check_model();
  endtask

  task automatic tick();
    bit acc;
    acc = m_accept();
    @(posedge clk);
    if (!resetn) model_reset();
    else if (acc) begin
      m_redir = 1;
      m_tgt   = bus.except_pc;
    end else if (m_redir) begin
      if (bus.redirect_ready) begin
        m_redir = 0;
        m_age   = 0;
      end
    end else if (m_age >= 0) begin
      if (m_age >= MIN_DRAIN - 1 && !bus.inst_pending) m_age = -1;
      else m_age++;
    end
  endtask

  task automatic idle_cyc(input logic rdy, input logic pend);
    drive(1, 0, 0, 0, 0, 0, 0, pend, rdy);
  endtask

  initial begin
    model_reset();

    // Reset held: outputs stay 0 even with an exception presented.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 32'd8, 32'h1234_5678, 32'h100, 0, 0, 0, 1);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      tick();
    end
    idle_cyc(1, 0);
    chk("rel_busy", 32'(bus.busy), 32'd0);
    tick();

    // Syscall, ready tied high
    drive(1, 1, 32'd8, 32'hBFC0_0380, 32'hBFC0_0100, 0, 0, 0, 1);
    chk("sys_flush", 32'(bus.flush_all), 32'd1);
    chk("sys_we",    32'(bus.cp0_except_we), 32'd1);
    chk("sys_code",  32'(bus.cp0_exccode), 32'd8);
    chk("sys_epc",   bus.cp0_epc_wdata, 32'hBFC0_0100);
    tick();
    idle_cyc(1, 0);
    chk("sys_rv",  32'(bus.redirect_valid), 32'd1);
    chk("sys_rpc", bus.redirect_pc, 32'hBFC0_0380);
    tick();
    idle_cyc(1, 0); chk("sys_drain1", 32'(bus.busy), 32'd1); tick();
    idle_cyc(1, 0); chk("sys_drain2", 32'(bus.busy), 32'd1); tick();
    idle_cyc(1, 0); chk("sys_idle",   32'(bus.busy), 32'd0); tick();

    // Delay slot, including EPC wrap from pc 0
    drive(1, 1, 32'd4, 32'hBFC0_0380, 32'h8000_0004, 1, 0, 0, 1);
    chk("ds_epc", bus.cp0_epc_wdata, 32'h8000_0000);
    chk("ds_bd",  32'(bus.cp0_bd), 32'd1);
    tick();
    for (int i = 0; i < 4; i++) begin idle_cyc(1, 0); tick(); end
    drive(1, 1, 32'd4, 32'hBFC0_0380, 32'h0, 1, 0, 0, 1);
    chk("wrap_epc", bus.cp0_epc_wdata, 32'hFFFF_FFFC);
    tick();
    for (int i = 0; i < 4; i++) begin idle_cyc(1, 0); tick(); end

    // ERET
    drive(1, 1, 32'h0e, 32'h8000_1000, 32'h8000_0200, 0, 0, 0, 1);
    chk("eret_p",  32'(bus.cp0_eret), 32'd1);
    chk("eret_we", 32'(bus.cp0_except_we), 32'd0);
    tick();
    idle_cyc(1, 0);
    chk("eret_rpc", bus.redirect_pc, 32'h8000_1000);
    tick();
    for (int i = 0; i < 3; i++) begin idle_cyc(1, 0); tick(); end

    // Backpressure: ready low 5 cycles, then pending 4 cycles in DRAIN,
    // with a stray exception presented while busy.
    drive(1, 1, 32'd10, 32'hBFC0_0380, 32'h8000_0040, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 32'd12, 32'hDEAD_BEEF, 32'h8000_0080, 0, 0, 0, 0);
      chk("bp_rv",  32'(bus.redirect_valid), 32'd1);
      chk("bp_rpc", bus.redirect_pc, 32'hBFC0_0380);
      tick();
    end
    idle_cyc(1, 1); tick();   // handshake
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 32'd12, 32'hDEAD_BEEF, 32'h8000_0080, 0, 0, 1, 1);
      chk("pend_busy", 32'(bus.busy), 32'd1);
      chk("pend_nowe", 32'(bus.cp0_except_we), 32'd0);
      tick();
    end
    idle_cyc(1, 0); chk("pend_exit", 32'(bus.busy), 32'd1); tick();
    idle_cyc(1, 0); chk("pend_idle", 32'(bus.busy), 32'd0); tick();

    // Stall blocks accept; then reset in the middle of REDIRECT
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 32'd8, 32'h8000_0180, 32'h8000_0300, 0, 1, 0, 0);
      chk("stall_nf", 32'(bus.flush_all), 32'd0);
      tick();
    end
    drive(1, 1, 32'd8, 32'h8000_0180, 32'h8000_0300, 0, 0, 0, 0);
    chk("stall_acc", 32'(bus.flush_all), 32'd1);
    tick();
    idle_cyc(0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("midrst_rv",   32'(bus.redirect_valid), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    tick();
    idle_cyc(1, 0); tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] typ, pc;
      typ = ($urandom_range(0, 3) == 0) ? 32'h0e : $urandom;
      pc  = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
      drive(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 9) < 3), typ, $urandom, pc,
            1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 9) < 4), ($urandom_range(0, 1) == 1));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
